sum_accumulator: RTL and testbench

Block accumulator that consumes the registered 17-bit sum stream produced by the adder stage and reduces each run of `len_i` consecutive valid sums to one 25-bit total. The result is presented on a valid/ready output port and held until accepted. Sums arriving while a result is still pending are dropped and counted. The block sits directly downstream of the adder and upstream of the result sink or scoreboard.

---
 rtl/sum_acc_pkg.sv | 18 +
 rtl/sum_accumulator.sv | 141 ++++++++++++++
 tb/tb_sum_accumulator.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg
//   Shared definitions for the sum accumulator: FSM state encoding and
//   default widths for the incoming sum, the block-length field, the
//   block total and the dropped-sample counter.
package sum_acc_pkg;

   localparam int SUM_W_DEF = 17;                    // adder output width
   localparam int LEN_W_DEF = 8;                     // block-length field; 0 means 2^LEN_W
   localparam int ACC_W_DEF = SUM_W_DEF + LEN_W_DEF; // wide enough that a full block never wraps
   localparam int DROP_W    = 8;                     // saturating dropped-sample counter

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } sum_acc_state_t;

endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Reduces each run of len_i consecutive valid sums from the adder stage to
//   one total and presents it on a valid/ready port until accepted.
//
//   Ports:
//     clk_i, rst_i   clock; asynchronous active-high reset
//     sum_valid_i    sum_i carries a new sample this cycle
//     sum_i          unsigned sample from the adder
//     len_i          samples per block, sampled on the first sample only;
//                    0 encodes 2^LEN_W
//     acc_valid_o    a completed block total is presented
//     acc_ready_i    sink accepts the total when high with acc_valid_o
//     acc_data_o     block total
//     acc_len_o      number of samples in the presented total
//     busy_o         a block is being accumulated or held
//     drop_cnt_o     saturating count of samples discarded while holding
//     state_o        current FSM state (observation only)
//
//   Handshake: a transfer happens on a rising edge where acc_valid_o and
//   acc_ready_i are both high. acc_valid_o never drops without a transfer
//   (except on reset) and acc_data_o/acc_len_o stay stable while it is
//   high. The sample side has no ready: samples arriving while a result is
//   held and not being accepted that cycle are dropped and counted.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int SUM_W = SUM_W_DEF,
   parameter int LEN_W = LEN_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                sum_valid_i,
   input  logic [SUM_W-1:0]    sum_i,
   input  logic [LEN_W-1:0]    len_i,
   output logic                acc_valid_o,
   input  logic                acc_ready_i,
   output logic [ACC_W-1:0]    acc_data_o,
   output logic [LEN_W:0]      acc_len_o,
   output logic                busy_o,
   output logic [DROP_W-1:0]   drop_cnt_o,
   output sum_acc_state_t      state_o
);

   sum_acc_state_t      state;
   sum_acc_state_t      state_nxt;

   logic [ACC_W-1:0]    acc;
   logic [LEN_W:0]      cnt;
   logic [LEN_W:0]      len_q;
   logic [DROP_W-1:0]   drop_cnt;

   logic [LEN_W:0]      len_eff;
   logic [LEN_W:0]      cnt_inc;
   logic [ACC_W-1:0]    sum_ext;
   logic                handshake;
   logic                start;
   logic                add;
   logic                drop;

   // A zero length field stands for the largest block, 2^LEN_W samples.
   assign len_eff   = (len_i == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_i};
   assign cnt_inc   = cnt + 1'b1;
   assign sum_ext   = {{(ACC_W-SUM_W){1'b0}}, sum_i};

   assign handshake = (state == ST_HOLD) && acc_ready_i;
   // A new block starts from IDLE, or from HOLD in the same cycle the held
   // total is accepted, so back-to-back blocks need no bubble.
   assign start     = sum_valid_i && ((state == ST_IDLE) || handshake);
   assign add       = sum_valid_i && (state == ST_ACCUM);
   assign drop      = sum_valid_i && (state == ST_HOLD) && !acc_ready_i;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (sum_valid_i) begin
               state_nxt = (len_eff == 1) ? ST_HOLD : ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (sum_valid_i && (cnt_inc == len_q)) begin
               state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (acc_ready_i) begin
               if (sum_valid_i) begin
                  state_nxt = (len_eff == 1) ? ST_HOLD : ST_ACCUM;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Accumulator, sample counter and latched block length
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else if (start) begin
         len_q <= len_eff;
         acc   <= sum_ext;
         cnt   <= {{LEN_W{1'b0}}, 1'b1};
      end else if (add) begin
         acc   <= acc + sum_ext;
         cnt   <= cnt_inc;
      end
   end

   // Dropped-sample counter; saturates and clears only on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != '1)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign acc_valid_o = (state == ST_HOLD);
   assign acc_data_o  = acc;
   assign acc_len_o   = cnt;
   assign busy_o      = (state != ST_IDLE);
   assign drop_cnt_o  = drop_cnt;
   assign state_o     = state;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator
//   Registered adder model feeding sum_accumulator. A reference model
//   follows the block rules on the DUT inputs and pushes each expected
//   {total, length} into exp_q; a monitor pops on every accepted result.
module tb_sum_accumulator;
   import sum_acc_pkg::*;

   localparam int SUM_W = 17;
   localparam int LEN_W = 8;
   localparam int ACC_W = 25;

   logic                clk;
   logic                rst;

   // adder stage inputs
   logic                add_valid;
   logic [15:0]         op_a;
   logic [15:0]         op_b;
   logic [LEN_W-1:0]    add_len;

   // adder stage outputs / accumulator inputs
   logic                sum_valid;
   logic [SUM_W-1:0]    sum;
   logic [LEN_W-1:0]    len;
   logic                acc_ready;

   logic                acc_valid;
   logic [ACC_W-1:0]    acc_data;
   logic [LEN_W:0]      acc_len;
   logic                busy;
   logic [7:0]          drop_cnt;
   sum_acc_state_t      state;

   int                  n_checks = 0;
   int                  n_errors = 0;

   logic [ACC_W+LEN_W:0] exp_q[$];

   // reference model state
   longint              m_blk[$];
   int                  m_len = 0;
   bit                  m_hold = 0;
   int                  m_drop = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- adder stage ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_valid <= 1'b0;
         sum       <= '0;
         len       <= '0;
      end else begin
         sum_valid <= add_valid;
         sum       <= {1'b0, op_a} + {1'b0, op_b};
         len       <= add_len;
      end
   end

   sum_accumulator #(.SUM_W(SUM_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sum_valid_i (sum_valid),
      .sum_i       (sum),
      .len_i       (len),
      .acc_valid_o (acc_valid),
      .acc_ready_i (acc_ready),
      .acc_data_o  (acc_data),
      .acc_len_o   (acc_len),
      .busy_o      (busy),
      .drop_cnt_o  (drop_cnt),
      .state_o     (state)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One cycle of stimulus: an adder sample (reaches the DUT next cycle)
   // and the sink ready for this cycle.
   task automatic drive(input bit v, input int val, input int l, input bit rdy);
      @(posedge clk);
      #1;
      add_valid = v;
      op_a      = 16'(val / 2);
      op_b      = 16'(val - val / 2);
      add_len   = 8'(l);
      acc_ready = rdy;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0, rdy);
   endtask

   // ---------------- reference model ----------------
   always @(negedge clk) begin
      if (rst) begin
         m_hold = 1'b0;
         m_blk.delete();
         m_drop = 0;
      end else begin
         chk("acc_valid", acc_valid, m_hold);
         chk("busy", busy, m_hold || (m_blk.size() > 0));
         chk("drop_cnt", drop_cnt, m_drop);
         if (m_hold && acc_ready) m_hold = 1'b0;
         if (sum_valid) begin
            if (m_hold) begin
               if (m_drop < 255) m_drop++;
            end else begin
               if (m_blk.size() == 0) m_len = (len == 0) ? 256 : int'(len);
               m_blk.push_back(longint'(sum));
               if (m_blk.size() == m_len) begin
                  longint total;
                  total = 0;
                  foreach (m_blk[i]) total += m_blk[i];
                  exp_q.push_back({ACC_W'(total), 9'(m_len)});
                  m_blk.delete();
                  m_hold = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && acc_valid && acc_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            logic [ACC_W+LEN_W:0] e;
            e = exp_q.pop_front();
            chk("acc_data", acc_data, e[ACC_W+LEN_W:LEN_W+1]);
            chk("acc_len", acc_len, e[LEN_W:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      add_valid = 1'b0; op_a = '0; op_b = '0; add_len = '0; acc_ready = 1'b0;
      #12;
      chk("rst_valid", acc_valid, 0);
      chk("rst_data", acc_data, 0);
      chk("rst_len", acc_len, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_state", state, ST_IDLE);
      @(posedge clk); #1 rst = 1'b0;

      // single block 1+2+3+4
      for (int i = 1; i <= 4; i++) drive(1'b1, i, 4, 1'b1);
      idle(4, 1'b1);
      chk("single_idle_state", state, ST_IDLE);

      // max block: 256 x 0x1FFFE
      for (int i = 0; i < 256; i++) drive(1'b1, 'h1FFFE, 0, 1'b1);
      idle(2, 1'b0);
      @(negedge clk);
      chk("max_data", acc_data, 33553920);
      chk("max_len", acc_len, 256);
      idle(3, 1'b1);

      // backpressure: 5+6 held while 3 samples are dropped
      drive(1'b1, 5, 2, 1'b0);
      drive(1'b1, 6, 2, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b1, 9, 2, 1'b0);
      idle(5, 1'b0);
      @(negedge clk);
      chk("bp_valid", acc_valid, 1);
      chk("bp_data", acc_data, 11);
      chk("bp_drop", drop_cnt, 3);
      idle(2, 1'b1);
      @(negedge clk);
      chk("bp_idle_busy", busy, 0);

      // handshake coincides with a len=1 sample
      drive(1'b1, 8, 2, 1'b0);
      drive(1'b1, 9, 2, 1'b0);
      idle(2, 1'b0);
      drive(1'b1, 7, 1, 1'b0);
      drive(1'b0, 0, 0, 1'b1);
      drive(1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk("simul_valid", acc_valid, 1);
      chk("simul_data", acc_data, 7);
      chk("simul_len", acc_len, 1);
      chk("simul_drop", drop_cnt, 3);
      idle(2, 1'b1);

      // gapped input, len change after first sample has no effect
      drive(1'b1, 100, 3, 1'b0);
      idle(5, 1'b0);
      drive(1'b1, 200, 9, 1'b0);
      drive(1'b1, 300, 9, 1'b0);
      idle(3, 1'b0);
      @(negedge clk);
      chk("gap_data", acc_data, 600);
      chk("gap_len", acc_len, 3);
      idle(2, 1'b1);

      // reset in the middle of a block
      drive(1'b1, 1, 4, 1'b0);
      drive(1'b1, 1, 4, 1'b0);
      idle(2, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_valid", acc_valid, 0);
      chk("midrst_data", acc_data, 0);
      chk("midrst_len", acc_len, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_drop", drop_cnt, 0);
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) drive(1'b1, 1, 4, 1'b0);
      idle(3, 1'b0);
      @(negedge clk);
      chk("postrst_data", acc_data, 4);
      chk("postrst_len", acc_len, 4);
      idle(2, 1'b1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         int l;
         l = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
         drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 131070)), l,
               $urandom_range(0, 2) != 0);
      end
      idle(400, 1'b1);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
